dmem_port_arbiter: RTL and testbench

Shares the single data-memory port (wr/rd/addr/wr_data/rd_data) between the pipeline MEM stage (port A) and a debug/program-loader master (port B). Port A has fixed priority. A starvation counter guarantees port B a slot after a bounded wait. Read responses are tracked through the memory's one-cycle read latency and returned to the owning port. The block sits between the datapath's MEM stage and the data memory, and it drives a stall request back to the pipeline.

---
 rtl/dmem_port_arbiter.sv | 99 +++++++++
 tb/tb_dmem_port_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the single-ported data memory: pipeline MEM stage (A)
// has fixed priority, debug/loader master (B) is guaranteed a slot after MAX_WAIT denials.
module dmem_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 9,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              core_stall,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_owner_q, rd_owner_d;

    logic force_b;
    logic grant_a;
    logic grant_b;

    assign force_b = b_req & (wait_cnt_q == CNT_MAX);
    assign grant_b = b_req & (~a_req | force_b);
    assign grant_a = a_req & ~grant_b;

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign core_stall = a_req & ~grant_a;

    always_comb begin
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (grant_b) begin
            mem_wr      = b_we;
            mem_rd      = ~b_we;
            mem_addr    = b_addr;
            mem_wr_data = b_wdata;
        end else if (grant_a) begin
            mem_wr      = a_we;
            mem_rd      = ~a_we;
            mem_addr    = a_addr;
            mem_wr_data = a_wdata;
        end
    end

    // Denial counter saturates so a long-starved B keeps its forced slot pending.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!b_req || grant_b) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    assign rd_pend_d  = mem_rd;
    assign rd_owner_d = grant_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign a_rvalid = rd_pend_q & ~rd_owner_q;
    assign b_rvalid = rd_pend_q & rd_owner_q;
    assign a_rdata  = a_rvalid ? mem_rd_data : '0;
    assign b_rdata  = b_rvalid ? mem_rd_data : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised bench for dmem_port_arbiter against a transaction-level model with a shadow memory.
module tb_dmem_port_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 9;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              a_req, a_we, b_req, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              a_ready, a_rvalid, b_ready, b_rvalid;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              core_stall, mem_wr, mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem    [DEPTH];
    logic [DATA_W-1:0] shadow [DEPTH];

    int                m_denied;
    bit                m_pend;
    bit                m_owner_b;
    logic [DATA_W-1:0] m_rdata;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .core_stall(core_stall), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    // Synchronous-read memory behind the arbiter.
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wr_data;
        if (mem_rd) mem_rd_data <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model.
    task automatic cycle(input bit ar, input bit aw, input logic [ADDR_W-1:0] aa,
                         input logic [DATA_W-1:0] ad, input bit br, input bit bw,
                         input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                         output bit ga, output bit gb);
        bit                win_b, sel_any, sel_we;
        logic [ADDR_W-1:0] sel_addr;
        logic [DATA_W-1:0] sel_data;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        #2;
        // B wins when A is idle or B has already been turned away MAX_WAIT times in a row.
        win_b = br && (!ar || m_denied >= MAX_WAIT);
        gb = win_b;
        ga = ar && !win_b;
        sel_any  = ga || gb;
        sel_we   = gb ? bw : aw;
        sel_addr = gb ? ba : (ga ? aa : '0);
        sel_data = gb ? bd : (ga ? ad : '0);
        check("a_ready", 64'(a_ready), 64'(ga));
        check("b_ready", 64'(b_ready), 64'(gb));
        check("core_stall", 64'(core_stall), 64'(ar && !ga));
        check("mem_wr", 64'(mem_wr), 64'(sel_any && sel_we));
        check("mem_rd", 64'(mem_rd), 64'(sel_any && !sel_we));
        check("mem_addr", 64'(mem_addr), 64'(sel_addr));
        check("mem_wr_data", 64'(mem_wr_data), 64'(sel_data));
        check("a_rvalid", 64'(a_rvalid), 64'(m_pend && !m_owner_b));
        check("b_rvalid", 64'(b_rvalid), 64'(m_pend && m_owner_b));
        check("a_rdata", 64'(a_rdata), 64'((m_pend && !m_owner_b) ? m_rdata : '0));
        check("b_rdata", 64'(b_rdata), 64'((m_pend && m_owner_b) ? m_rdata : '0));
        m_pend    = sel_any && !sel_we;
        m_owner_b = gb;
        if (sel_any) begin
            if (sel_we) shadow[sel_addr] = sel_data;
            else        m_rdata = shadow[sel_addr];
        end
        if (!br || gb) m_denied = 0;
        else if (m_denied < MAX_WAIT) m_denied++;
        $display("cyc t=%0t A(%0b,%0b,%0h) B(%0b,%0b,%0h) ga=%0b gb=%0b", $time,
                 ar, aw, aa, br, bw, ba, ga, gb);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        bit ga, gb;
        cycle(0, 0, '0, '0, 0, 0, '0, '0, ga, gb);
    endtask

    initial begin
        bit ga, gb;
        bit pa, pb, awe_r, bwe_r;
        logic [ADDR_W-1:0] aad_r, bad_r;
        logic [DATA_W-1:0] awd_r, bwd_r;
        int b_grant_idx;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = $urandom;
            shadow[i] = mem[i];
        end
        mem[9'h010] = 32'hDEADBEEF;
        shadow[9'h010] = 32'hDEADBEEF;
        m_denied = 0; m_pend = 0; m_owner_b = 0; m_rdata = '0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;

        reset = 1'b1;
        #2;
        check("rst_a_rvalid", 64'(a_rvalid), 64'(0));
        check("rst_b_rvalid", 64'(b_rvalid), 64'(0));
        check("rst_a_rdata", 64'(a_rdata), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single A read of 0x010, then idle to see the response.
        cycle(1, 0, 9'h010, '0, 0, 0, '0, '0, ga, gb);
        idle_cycle();

        // Continuous contention: B must win on the (MAX_WAIT+1)th cycle.
        b_grant_idx = -1;
        for (int c = 0; c < MAX_WAIT + 3; c++) begin
            cycle(1, 0, ADDR_W'(c), '0, (b_grant_idx < 0), 0, 9'h1F0, '0, ga, gb);
            if (gb) b_grant_idx = c;
        end
        check("contention_b_slot", 64'(b_grant_idx), 64'(MAX_WAIT));
        idle_cycle();

        // B-only write to the top address, response-free.
        cycle(0, 0, '0, '0, 1, 1, 9'h1FF, 32'h12345678, ga, gb);
        idle_cycle();
        check("wr_landed", 64'(mem[9'h1FF]), 64'(32'h12345678));

        // Interleaved A read then B read.
        cycle(1, 0, 9'h1FF, '0, 0, 0, '0, '0, ga, gb);
        cycle(0, 0, '0, '0, 1, 0, 9'h010, '0, ga, gb);
        idle_cycle();

        // Asynchronous reset while an A response is outstanding.
        cycle(1, 0, 9'h010, '0, 0, 0, '0, '0, ga, gb);
        check("pre_rst_a_rvalid", 64'(a_rvalid), 64'(1));
        reset = 1'b1;
        #1;
        check("async_rst_a_rvalid", 64'(a_rvalid), 64'(0));
        m_pend = 0; m_owner_b = 0; m_denied = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        idle_cycle();

        // Contention right after reset confirms the denial counter restarted at zero.
        b_grant_idx = -1;
        for (int c = 0; c < MAX_WAIT + 2; c++) begin
            cycle(1, 1, ADDR_W'(c + 32), 32'(c), (b_grant_idx < 0), 0, '0, '0, ga, gb);
            if (gb) b_grant_idx = c;
        end
        check("post_rst_b_slot", 64'(b_grant_idx), 64'(MAX_WAIT));

        for (int c = 0; c < 10; c++) idle_cycle();

        // Randomised traffic with both masters obeying hold-until-ready.
        pa = 0; pb = 0;
        awe_r = 0; bwe_r = 0; aad_r = '0; bad_r = '0; awd_r = '0; bwd_r = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pa && ($urandom_range(3) != 0)) begin
                pa = 1; awe_r = $urandom_range(1) == 1;
                aad_r = ($urandom_range(7) == 0) ? 9'h1FF : ADDR_W'($urandom_range(15));
                awd_r = $urandom;
            end
            if (!pb && ($urandom_range(2) != 0)) begin
                pb = 1; bwe_r = $urandom_range(1) == 1;
                bad_r = ($urandom_range(7) == 0) ? 9'h000 : ADDR_W'($urandom_range(15));
                bwd_r = $urandom;
            end
            cycle(pa, awe_r, aad_r, awd_r, pb, bwe_r, bad_r, bwd_r, ga, gb);
            if (ga) pa = 0;
            if (gb) pb = 0;
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
